// File: rtl/wb_ddr_arbiter.sv
// Round-robin Wishbone arbiter sharing the DDR controller port between bus masters, with a hung-transfer watchdog.
// Latency: one arbitration cycle from request to slave stb, then a combinational pass-through while granted.
// Backpressure: waiting masters stall until granted; the slave's ack paces the winner, and a silent slave is ended with err.
module wb_ddr_arbiter #(
    parameter int num_masters = 3,
    parameter int timeout     = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [num_masters-1:0]    m_cyc_i,
    input  logic [num_masters-1:0]    m_stb_i,
    input  logic [num_masters-1:0]    m_we_i,
    input  logic [32*num_masters-1:0] m_adr_i,
    input  logic [32*num_masters-1:0] m_dat_i,
    input  logic [4*num_masters-1:0]  m_sel_i,
    output logic [31:0]               m_dat_o,
    output logic [num_masters-1:0]    m_ack_o,
    output logic [num_masters-1:0]    m_err_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [31:0]               s_adr_o,
    output logic [31:0]               s_dat_o,
    output logic [3:0]                s_sel_o,
    input  logic [31:0]               s_dat_i,
    input  logic                      s_ack_i,
    output logic [num_masters-1:0]    grant_o,
    output logic                      timeout_o
);

    localparam int IW = 2;

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t                   state, state_nxt;
    logic [IW-1:0]            gidx, last, arb_idx;
    logic                     arb_found;
    logic [num_masters-1:0]   req, grant_q;
    logic [9:0]               wd_cnt;
    logic                     expire;

    assign req     = m_cyc_i & m_stb_i;
    assign m_dat_o = s_dat_i;
    assign grant_o = grant_q;

    // Search starts just past the last winner so every requester is reached within num_masters grants.
    always_comb begin
        int c;
        c         = 0;
        arb_found = 1'b0;
        arb_idx   = last;
        for (int i = 1; i <= num_masters; i++) begin
            c = (int'(last) + i) % num_masters;
            if (!arb_found && req[c]) begin
                arb_found = 1'b1;
                arb_idx   = IW'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gidx    <= '0;
            last    <= IW'(num_masters - 1);
            grant_q <= '0;
            wd_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && arb_found) begin
                gidx    <= arb_idx;
                last    <= arb_idx;
                grant_q <= {{(num_masters-1){1'b0}}, 1'b1} << arb_idx;
            end else if (state_nxt == IDLE) begin
                grant_q <= '0;
            end
            if (!s_stb_o || s_ack_i || expire)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 10'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_found) state_nxt = GRANT;
            GRANT:   if (!m_cyc_i[gidx]) state_nxt = IDLE;
                     else if (expire)    state_nxt = DRAIN;
            DRAIN:   if (!m_cyc_i[gidx]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // DRAIN keeps the slave idle until the faulty master gives up its cycle.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        timeout_o = 1'b0;
        expire    = 1'b0;
        if (state == GRANT) begin
            s_cyc_o       = m_cyc_i[gidx];
            s_stb_o       = m_cyc_i[gidx] & m_stb_i[gidx];
            s_we_o        = m_we_i[gidx];
            s_adr_o       = m_adr_i[32*gidx +: 32];
            s_dat_o       = m_dat_i[32*gidx +: 32];
            s_sel_o       = m_sel_i[4*gidx +: 4];
            m_ack_o[gidx] = s_ack_i;
            expire        = s_stb_o && !s_ack_i && (wd_cnt == 10'(timeout));
            m_err_o[gidx] = expire;
            timeout_o     = expire;
        end
    end

endmodule

// File: tb/tb_wb_ddr_arbiter.sv
// Directed bench for wb_ddr_arbiter: single read, round robin, held grant, watchdog, ack at expiry, reset mid-transfer.
// Latency: n/a. Backpressure: the bench plays the DDR slave and drives ack by hand.
module tb_wb_ddr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  m_cyc, m_stb, m_we;
    logic [95:0] m_adr, m_dat;
    logic [11:0] m_sel;
    logic [31:0] m_dat_o;
    logic [2:0]  m_ack_o, m_err_o, grant_o;
    logic        s_cyc_o, s_stb_o, s_we_o, timeout_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_ack_i;

    int checks   = 0;
    int failures = 0;

    wb_ddr_arbiter #(.num_masters(3), .timeout(1023)) dut (
        .clk(clk), .reset(reset),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_adr = '0; m_dat = '0; m_sel = '0;
        s_dat_i = '0; s_ack_i = 1'b0;
        tick; tick;
        checks++; if (grant_o !== 3'b000) begin failures++; $display("FAIL reset_grant got=%b want=000", grant_o); end
        checks++; if ({s_cyc_o, s_stb_o} !== 2'b00) begin failures++; $display("FAIL reset_slave got=%b want=00", {s_cyc_o, s_stb_o}); end
        checks++; if ({m_ack_o, m_err_o, timeout_o} !== 7'b0) begin failures++; $display("FAIL reset_resp got=%b want=0", {m_ack_o, m_err_o, timeout_o}); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_single_read;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0;
        m_adr[31:0] = 32'h4000_0010; m_sel[3:0] = 4'hF;
        #1;
        checks++; if ({grant_o, s_stb_o} !== 4'b0000) begin failures++; $display("FAIL read_arb_cycle got=%b want=0000", {grant_o, s_stb_o}); end
        tick;
        checks++; if (grant_o !== 3'b001) begin failures++; $display("FAIL read_grant got=%b want=001", grant_o); end
        checks++; if (s_stb_o !== 1'b1 || s_adr_o !== 32'h4000_0010 || s_we_o !== 1'b0) begin
            failures++; $display("FAIL read_slave_req stb=%b adr=%h we=%b want 1/40000010/0", s_stb_o, s_adr_o, s_we_o); end
        tick;
        checks++; if (m_ack_o !== 3'b000) begin failures++; $display("FAIL read_early_ack got=%b want=000", m_ack_o); end
        tick;
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF; #1;
        checks++; if (m_ack_o !== 3'b001) begin failures++; $display("FAIL read_ack got=%b want=001", m_ack_o); end
        checks++; if (m_dat_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_data got=%h want=deadbeef", m_dat_o); end
        tick;
        s_ack_i = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0; #1;
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL read_drop_cyc got=%b want=0", s_cyc_o); end
        tick;
        checks++; if (grant_o !== 3'b000) begin failures++; $display("FAIL read_idle got=%b want=000", grant_o); end
    endtask

    task automatic test_round_robin;
        logic [2:0] exp_g [6];
        logic [2:0] dropped;
        int acks;
        int gap;
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        dropped = '0; acks = 0; gap = 0;
        reset = 1'b1; tick; reset = 1'b0;
        for (int n = 0; n < 60 && acks < 6; n++) begin
            m_cyc = ~dropped; m_stb = ~dropped; #1;
            s_ack_i = s_stb_o; #1;
            if (m_ack_o !== 3'b000) begin
                checks++; if (m_ack_o !== exp_g[acks]) begin failures++; $display("FAIL rr_order idx=%0d got=%b want=%b", acks, m_ack_o, exp_g[acks]); end
                if (acks > 0) begin
                    checks++; if (gap != 2) begin failures++; $display("FAIL rr_gap idx=%0d got=%0d want=2", acks, gap); end
                end
                gap = 0;
                acks++;
            end else if (!s_cyc_o) begin
                gap++;
            end
            dropped = m_ack_o;
            tick;
        end
        checks++; if (acks != 6) begin failures++; $display("FAIL rr_count got=%0d want=6", acks); end
        m_cyc = '0; m_stb = '0; s_ack_i = 1'b0;
        tick; tick;
    endtask

    task automatic test_hold_grant;
        m_cyc = 3'b110; m_stb = 3'b110;
        m_adr[63:32] = 32'h4000_0100; m_adr[95:64] = 32'h4000_0200;
        tick;
        for (int p = 0; p < 3; p++) begin
            m_stb[1] = 1'b1; s_ack_i = 1'b1; #1;
            checks++; if (m_ack_o !== 3'b010) begin failures++; $display("FAIL hold_ack phase=%0d got=%b want=010", p, m_ack_o); end
            tick;
            m_stb[1] = 1'b0; s_ack_i = 1'b0; #1;
            checks++; if (grant_o !== 3'b010 || m_ack_o !== 3'b000) begin
                failures++; $display("FAIL hold_gap phase=%0d grant=%b ack=%b want 010/000", p, grant_o, m_ack_o); end
            tick;
        end
        m_cyc[1] = 1'b0; #1;
        checks++; if (s_cyc_o !== 1'b0 || m_ack_o[2] !== 1'b0) begin failures++; $display("FAIL hold_drop cyc=%b ack2=%b want 0/0", s_cyc_o, m_ack_o[2]); end
        tick;
        checks++; if (grant_o !== 3'b000) begin failures++; $display("FAIL hold_idle got=%b want=000", grant_o); end
        tick;
        checks++; if (grant_o !== 3'b100 || s_adr_o !== 32'h4000_0200) begin failures++; $display("FAIL hold_next grant=%b adr=%h want 100/40000200", grant_o, s_adr_o); end
        s_ack_i = 1'b1; #1;
        checks++; if (m_ack_o !== 3'b100) begin failures++; $display("FAIL hold_m2_ack got=%b want=100", m_ack_o); end
        tick;
        m_cyc = '0; m_stb = '0; s_ack_i = 1'b0;
        tick; tick;
    endtask

    task automatic test_watchdog;
        int hit;
        int pulses;
        hit = -1; pulses = 0;
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1; m_dat[95:64] = 32'hCAFE_F00D;
        tick;
        for (int i = 0; i < 1100; i++) begin
            if (timeout_o) pulses++;
            if (m_err_o !== 3'b000) begin
                hit = i;
                checks++; if (m_err_o !== 3'b100 || timeout_o !== 1'b1) begin
                    failures++; $display("FAIL wd_err err=%b tmo=%b want 100/1", m_err_o, timeout_o); end
                break;
            end
            tick;
        end
        checks++; if (hit != 1023) begin failures++; $display("FAIL wd_expiry_cycle got=%0d want=1023", hit); end
        tick;
        if (timeout_o) pulses++;
        checks++; if (pulses != 1) begin failures++; $display("FAIL wd_pulse_count got=%0d want=1", pulses); end
        checks++; if ({s_cyc_o, s_stb_o, m_err_o, m_ack_o} !== 8'b0 || grant_o !== 3'b100) begin
            failures++; $display("FAIL wd_drain cyc=%b err=%b ack=%b grant=%b want 0/000/000/100", s_cyc_o, m_err_o, m_ack_o, grant_o); end
        tick; tick; tick;
        checks++; if (s_cyc_o !== 1'b0 || timeout_o !== 1'b0) begin failures++; $display("FAIL wd_drain_hold cyc=%b tmo=%b want 0/0", s_cyc_o, timeout_o); end
        m_cyc = '0; m_stb = '0; m_we = '0;
        tick;
        checks++; if (grant_o !== 3'b000) begin failures++; $display("FAIL wd_idle got=%b want=000", grant_o); end
    endtask

    task automatic test_ack_at_expiry;
        int errs;
        errs = 0;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick;
        for (int i = 0; i < 1023; i++) begin
            if (m_err_o !== 3'b000 || timeout_o) errs++;
            tick;
        end
        checks++; if (errs != 0) begin failures++; $display("FAIL ae_early_err got=%0d want=0", errs); end
        s_ack_i = 1'b1; s_dat_i = 32'h1234_5678; #1;
        checks++; if (m_ack_o !== 3'b001 || m_err_o !== 3'b000 || timeout_o !== 1'b0) begin
            failures++; $display("FAIL ae_ack_wins ack=%b err=%b tmo=%b want 001/000/0", m_ack_o, m_err_o, timeout_o); end
        tick;
        s_ack_i = 1'b0; m_cyc = '0; m_stb = '0; #1;
        checks++; if (m_err_o !== 3'b000 || timeout_o !== 1'b0) begin failures++; $display("FAIL ae_after err=%b tmo=%b want 000/0", m_err_o, timeout_o); end
        tick;
    endtask

    task automatic test_reset_midxfer;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        tick; tick; tick;
        checks++; if (grant_o !== 3'b001 || s_cyc_o !== 1'b1) begin failures++; $display("FAIL rm_stalled grant=%b cyc=%b want 001/1", grant_o, s_cyc_o); end
        reset = 1'b1; m_cyc = 3'b111; m_stb = 3'b111;
        tick;
        s_ack_i = 1'b1; #1;
        checks++; if (s_cyc_o !== 1'b0 || grant_o !== 3'b000 || m_ack_o !== 3'b000) begin
            failures++; $display("FAIL rm_after_reset cyc=%b grant=%b ack=%b want 0/000/000", s_cyc_o, grant_o, m_ack_o); end
        reset = 1'b0; s_ack_i = 1'b0;
        tick;
        checks++; if (grant_o !== 3'b001) begin failures++; $display("FAIL rm_first_arb got=%b want=001", grant_o); end
        m_cyc = '0; m_stb = '0;
        tick; tick;
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout sim time exceeded");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset;
        test_single_read;
        test_round_robin;
        test_hold_grant;
        test_watchdog;
        test_ack_at_expiry;
        test_reset_midxfer;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
